control_unit: RTL and testbench

Main decoder of the 32-bit single-cycle/pipelined datapath. Takes the 6-bit instruction opcode and produces the datapath control signals: register-destination select, ALU operand-B select, register-file write enable, jump select and the 2-bit ALU operation class. Outputs are registered (one clock of latency), so the block sits at the decode/execute boundary. Unrecognised opcodes produce a safe no-op with an illegal-instruction flag.

---
 rtl/control_pkg.sv | 26 ++
 rtl/control_if.sv | 25 ++
 rtl/control_decode.sv | 27 ++
 rtl/control_unit.sv | 45 ++++
 tb/tb_control_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the main decoder: opcodes, ALU classes and
// the control bundle consumed by ALU-control and the datapath.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_MOVI  = 6'b001010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001001;
    localparam logic [5:0] OP_JUMP  = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc;
        logic       RegWrite;
        logic       Jump;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_if.sv
// Decoder boundary bundle: instruction in, registered controls out.
// The slave side is the decoder, the master side is the fetch/decode stage.
interface control_if;

    logic       valid_in;
    logic [5:0] opcode;
    logic       RegDst;
    logic       ALUSrc;
    logic       RegWrite;
    logic       Jump;
    logic [1:0] ALUOp;
    logic       valid_out;
    logic       Illegal;

    modport master (
        output valid_in, opcode,
        input  RegDst, ALUSrc, RegWrite, Jump, ALUOp, valid_out, Illegal
    );

    modport slave (
        input  valid_in, opcode,
        output RegDst, ALUSrc, RegWrite, Jump, ALUOp, valid_out, Illegal
    );

endinterface

// File: rtl/control_decode.sv
// Combinational opcode decoder. Bubbles and unknown opcodes collapse
// to a no-op so nothing downstream can write or jump.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_valid,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b0;
        if (i_valid) begin
            case (i_opcode)
                OP_RTYPE: o_ctrl = ctrl_t'{1'b1, 1'b0, 1'b1, 1'b0, ALUOP_FUNCT};
                OP_MOVI:  o_ctrl = ctrl_t'{1'b0, 1'b1, 1'b1, 1'b0, ALUOP_PASSB};
                OP_ADDI:  o_ctrl = ctrl_t'{1'b0, 1'b1, 1'b1, 1'b0, ALUOP_ADD};
                OP_SUBI:  o_ctrl = ctrl_t'{1'b0, 1'b1, 1'b1, 1'b0, ALUOP_SUB};
                OP_JUMP:  o_ctrl = ctrl_t'{1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
                default:  o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder with a registered output stage at the decode/execute
// boundary; every output comes straight from a flop.
module control_unit
    import control_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    control_if.slave  bus
);

    ctrl_t w_ctrl;
    logic  w_illegal;

    ctrl_t r_ctrl;
    logic  r_valid;
    logic  r_illegal;

    control_decode u_decode (
        .i_opcode  (bus.opcode),
        .i_valid   (bus.valid_in),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= CTRL_NOP;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ctrl    <= w_ctrl;
            r_valid   <= bus.valid_in;
            r_illegal <= w_illegal;
        end
    end

    assign bus.RegDst    = r_ctrl.RegDst;
    assign bus.ALUSrc    = r_ctrl.ALUSrc;
    assign bus.RegWrite  = r_ctrl.RegWrite;
    assign bus.Jump      = r_ctrl.Jump;
    assign bus.ALUOp     = r_ctrl.ALUOp;
    assign bus.valid_out = r_valid;
    assign bus.Illegal   = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit.
// Observed word: {RegDst,ALUSrc,RegWrite,Jump,ALUOp,valid_out,Illegal}.
module tb_control_unit;

    logic clk;
    logic rst;

    control_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] obs;
    assign obs = {bus.RegDst, bus.ALUSrc, bus.RegWrite, bus.Jump,
                  bus.ALUOp, bus.valid_out, bus.Illegal};

    localparam logic [7:0] E_RTYPE = 8'b1010_1010;
    localparam logic [7:0] E_MOVI  = 8'b0110_1110;
    localparam logic [7:0] E_ADDI  = 8'b0110_0010;
    localparam logic [7:0] E_SUBI  = 8'b0110_0110;
    localparam logic [7:0] E_JUMP  = 8'b0001_0010;
    localparam logic [7:0] E_ILL   = 8'b0000_0011;
    localparam logic [7:0] E_ZERO  = 8'b0000_0000;

    function automatic logic [7:0] model(input logic [5:0] op, input logic v);
        if (!v) return E_ZERO;
        case (op)
            6'b000000: return E_RTYPE;
            6'b001010: return E_MOVI;
            6'b001000: return E_ADDI;
            6'b001001: return E_SUBI;
            6'b000010: return E_JUMP;
            default:   return E_ILL;
        endcase
    endfunction

    // inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'b000000;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== E_ZERO) begin
                bad++;
                $display("FAIL reset_%0d got=%b exp=%b", i, obs, E_ZERO);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (obs !== E_RTYPE) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", obs, E_RTYPE);
        end
    endtask

    task automatic test_table();
        logic [5:0] ops [6];
        logic [7:0] exps [6];
        ops  = '{6'b000000, 6'b001010, 6'b001000, 6'b001001, 6'b000010, 6'b111111};
        exps = '{E_RTYPE, E_MOVI, E_ADDI, E_SUBI, E_JUMP, E_ILL};
        bus.valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.opcode = ops[i];
            tick();
            total++;
            if (obs !== exps[i]) begin
                bad++;
                $display("FAIL table op=%b got=%b exp=%b", ops[i], obs, exps[i]);
            end
        end
    endtask

    task automatic test_bubble();
        bus.opcode = 6'b000010;
        bus.valid_in = 1'b0;
        tick();
        total++;
        if (obs !== E_ZERO) begin
            bad++;
            $display("FAIL bubble_jump got=%b exp=%b", obs, E_ZERO);
        end
        bus.opcode = 6'b111111;
        tick();
        total++;
        if (obs !== E_ZERO) begin
            bad++;
            $display("FAIL bubble_illegal got=%b exp=%b", obs, E_ZERO);
        end
    endtask

    task automatic test_exhaustive();
        int n_ill;
        logic known;
        n_ill = 0;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.opcode = 6'(i);
            tick();
            known = (i == 0) || (i == 10) || (i == 8) || (i == 9) || (i == 2);
            if (bus.Illegal === 1'b1) n_ill++;
            total++;
            if (bus.Illegal !== !known) begin
                bad++;
                $display("FAIL exh_illegal op=%0d got=%b exp=%b", i, bus.Illegal, !known);
            end
            total++;
            if ((bus.RegWrite & bus.Jump) !== 1'b0) begin
                bad++;
                $display("FAIL exh_wr_jump op=%0d got=1 exp=0", i);
            end
            total++;
            if (!known && obs !== E_ILL) begin
                bad++;
                $display("FAIL exh_nop op=%0d got=%b exp=%b", i, obs, E_ILL);
            end
        end
        total++;
        if (n_ill != 59) begin
            bad++;
            $display("FAIL exh_count got=%0d exp=59", n_ill);
        end
    endtask

    task automatic test_midreset();
        bus.valid_in = 1'b1;
        bus.opcode = 6'b001000;
        tick();
        total++;
        if (obs !== E_ADDI) begin
            bad++;
            $display("FAIL mid_addi got=%b exp=%b", obs, E_ADDI);
        end
        rst = 1'b1;
        bus.opcode = 6'b001001;
        tick();
        total++;
        if (obs !== E_ZERO) begin
            bad++;
            $display("FAIL mid_rst got=%b exp=%b", obs, E_ZERO);
        end
        rst = 1'b0;
        bus.opcode = 6'b000010;
        tick();
        total++;
        if (obs !== E_JUMP) begin
            bad++;
            $display("FAIL mid_jump got=%b exp=%b", obs, E_JUMP);
        end
    endtask

    // outputs must hold the previous result until the next edge
    task automatic test_latency();
        logic [5:0] op;
        logic       v;
        logic [7:0] prev;
        prev = obs;
        for (int i = 0; i < 40; i++) begin
            op = 6'($urandom_range(0, 15));
            v  = ($urandom_range(0, 3) != 0);
            bus.opcode = op;
            bus.valid_in = v;
            #3;
            total++;
            if (obs !== prev) begin
                bad++;
                $display("FAIL lat_hold i=%0d got=%b exp=%b", i, obs, prev);
            end
            tick();
            prev = model(op, v);
            total++;
            if (obs !== prev) begin
                bad++;
                $display("FAIL lat_next i=%0d op=%b v=%b got=%b exp=%b",
                         i, op, v, obs, prev);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.valid_in = 1'b1;
        bus.opcode = 6'b111110;
        tick();
        total++;
        if (obs !== E_ILL) begin
            bad++;
            $display("FAIL b2b_ill got=%b exp=%b", obs, E_ILL);
        end
        bus.opcode = 6'b001010;
        tick();
        total++;
        if (obs !== E_MOVI) begin
            bad++;
            $display("FAIL b2b_movi got=%b exp=%b", obs, E_MOVI);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.opcode = 6'b0;
        #1;
        test_reset();
        test_table();
        test_bubble();
        test_exhaustive();
        test_midreset();
        test_back_to_back();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
